ta_fifo_in: RTL and testbench
=============================

// Module: ta_fifo_in
// PURPOSE
//  SH4-side write port for the TA FIFO region (phys 0x10000000-0x107FFFFF). It sits between the SH4 data-memory
//  request bus and the pvr block's TA input, upstream of the TA parameter parser. It accepts 64/32-bit stores,
//  splits them into 32-bit words and buffers them, then streams them to the parser with a ready/valid handshake.
//  The output marks every 8th word (one 32-byte TA parameter block) as last.
// PARAMETERS
//  DEPTH    64           word FIFO depth; power of 2, >=8
//  REG_HI   29'h107FFFFF region upper bound (inclusive), compared on req_addr[28:0]
//  REG_LO   29'h10000000 region lower bound (inclusive)
// PORTS
//  clk          in  1   clock; the only clock
//  rst          in  1   synchronous, active-high reset
//  req_valid    in  1   SH4 request valid; held until resp_valid
//  req_addr     in  32  byte address; bits [28:0] decoded
//  req_wdata    in  64  store data
//  req_wmask    in  8   byte mask
//  req_wen      in  1   1=write, 0=read
//  resp_valid   out 1   1-cycle ack for a request hitting the region
//  resp_rdata   out 64  read data; always 0 (region is write-only)
//  ta_valid     out 1   word available
//  ta_word      out 32  FIFO head word
//  ta_last      out 1   head word is word 7 of a 32-byte block
//  ta_ready     in  1   parser accepts head word
//  level        out $clog2(DEPTH)+1  words currently buffered
//  mask_err     out 1   sticky: write with unsupported wmask dropped
//  err_clr      in  1   clears mask_err
// BEHAVIOUR
//  Reset: state=IDLE; resp_valid, ta_valid, ta_last, mask_err = 0; level = 0; resp_rdata = 0; block word count = 0.
//  Hit = req_valid && REG_LO <= req_addr[28:0] <= REG_HI. Non-hits are ignored entirely (no ack).
//  FSM IDLE/PUSH_LO/PUSH_HI/ACK:
//   IDLE: on hit, capture addr/data/mask/wen into a holding register. Next state:
//    - read -> ACK;
//    - wmask 8'hFF -> PUSH_LO; 8'h0F -> PUSH_LO (single word); 8'hF0 -> PUSH_HI;
//    - any other mask -> set mask_err, go to ACK (data dropped).
//   PUSH_LO: push wdata[31:0] when the FIFO is not full, else stay. Next: PUSH_HI if mask=FF, else ACK.
//   PUSH_HI: push wdata[63:32] when not full, else stay. Next: ACK.
//   ACK: resp_valid=1 for exactly one cycle; next state IDLE. The requester drops req_valid or presents a new
//    request in the following cycle; IDLE never samples during ACK.
//  Latency, no stall: FF mask -> resp_valid 3 cycles after capture; 0F/F0 -> 2; read/bad mask -> 1.
//  Word order in the FIFO: the low word precedes the high word; requests are kept in acceptance order.
//  Output: ta_valid = level != 0. A pop occurs on ta_valid && ta_ready; ta_word/ta_last are combinational from
//   the head. ta_last = (blk_cnt == 7). blk_cnt is 3 bits, increments per pop and wraps 7->0.
//  Simultaneous push+pop: level unchanged. Push+pop when full is impossible (push requires !full before the pop).
//  Empty: ta_valid=0; ta_ready ignored. Full: FSM holds in PUSH_x with resp_valid withheld (SH4 stalls).
//  err_clr has priority over a same-cycle set of mask_err.
//  rst mid-request: FIFO flushed, blk_cnt=0, FSM to IDLE, and no resp_valid for the aborted request.
// STRUCTURE
//  Package pvr_pkg: TA_FIFO_LO/HI region constants and the FSM state enum (shared with the pvr address decode).
//  One sub-module: sync_fifo_w32 (DEPTH x 32, registered pointers with an extra wrap bit, level output,
//   push/pop/full/empty). The FSM, region decode, blk_cnt and error flag stay in ta_fifo_in.
// TESTING
//  1. Write 0x10000000, data 64'h11112222_33334444, mask FF, ta_ready=1 -> resp_valid 3 cycles after capture;
//     words 0x33334444 then 0x11112222.
//  2. Four FF writes (8 words), ta_ready=1 -> ta_last high only on word 8; a 9th word gives ta_last=0
//     (blk_cnt wrapped).
//  3. ta_ready=0, DEPTH=64, issue 33 FF writes -> 32 acked, level=64, 33rd has no resp_valid; raising ta_ready
//     completes the 33rd with data in order.
//  4. Mask 8'h3C -> resp_valid after 1 cycle, level unchanged, mask_err=1; err_clr pulse -> mask_err=0.
//  5. Read 0x10000010 -> resp_valid, resp_rdata=0. Write 0x005F7C00 -> no resp_valid, level unchanged.
//  6. rst asserted during PUSH_HI with level=5 -> next cycle level=0, ta_valid=0, no ack; a later write works.

Source files
------------

// File: rtl/ta_fifo_in_pkg.sv
// Shared definitions for the SH4-side TA FIFO write port.
//   TA_FIFO_LO / TA_FIFO_HI : inclusive bounds of the TA FIFO region on addr[28:0]
//   ta_state_e              : request FSM states (IDLE, PUSH_LO, PUSH_HI, ACK)
//   in_region()             : inclusive range test used by the region decode
package ta_fifo_in_pkg;

  localparam logic [28:0] TA_FIFO_LO = 29'h1000_0000;
  localparam logic [28:0] TA_FIFO_HI = 29'h107F_FFFF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PUSH_LO = 2'd1,
    PUSH_HI = 2'd2,
    ACK     = 2'd3
  } ta_state_e;

  function automatic logic in_region(input logic [28:0] addr,
                                     input logic [28:0] lo,
                                     input logic [28:0] hi);
    return (addr >= lo) && (addr <= hi);
  endfunction

endpackage

// File: rtl/ta_fifo_in_if.sv
// Bus bundle for ta_fifo_in: SH4 data-memory request/response plus the TA
// word stream toward the parameter parser.
//   master : SH4 requester and parser consumer (drives req_*, ta_ready)
//   slave  : ta_fifo_in (drives resp_*, ta_valid, ta_word, ta_last)
interface ta_fifo_in_if;

  logic        req_valid;
  logic [31:0] req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_wmask;
  logic        req_wen;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        ta_valid;
  logic [31:0] ta_word;
  logic        ta_last;
  logic        ta_ready;

  modport master (
    output req_valid, req_addr, req_wdata, req_wmask, req_wen, ta_ready,
    input  resp_valid, resp_rdata, ta_valid, ta_word, ta_last
  );

  modport slave (
    input  req_valid, req_addr, req_wdata, req_wmask, req_wen, ta_ready,
    output resp_valid, resp_rdata, ta_valid, ta_word, ta_last
  );

endinterface

// File: rtl/ta_fifo_in_sync_fifo_w32.sv
// DEPTH x 32-bit synchronous FIFO with registered read/write pointers that
// carry one extra wrap bit, so full and empty are told apart by the pointer
// difference alone.
//   clk, rst     : clock, synchronous active-high reset (flushes pointers)
//   push, wdata  : write one word (ignored when full)
//   pop, rdata   : drop the head word (ignored when empty); rdata is the head
//   full, empty  : occupancy flags
//   level        : words currently stored, 0..DEPTH
module sync_fifo_w32 #(
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [31:0]              wdata,
  input  logic                     pop,
  output logic [31:0]              rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0] mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;

  assign level = wr_ptr_q - rd_ptr_q;
  assign full  = (level == (AW+1)'(DEPTH));
  assign empty = (level == '0);
  assign rdata = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q + (AW+1)'(push && !full);
    rd_ptr_d = rd_ptr_q + (AW+1)'(pop && !empty);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: the storage array has no reset; a flush only clears the pointers,
  // and stale words are never visible because empty gates the read side.
  always_ff @(posedge clk) begin
    if (push && !full) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/ta_fifo_in.sv
// SH4-side write port for the TA FIFO region. Accepts 64/32-bit stores that
// hit [REG_LO, REG_HI] on addr[28:0], splits them into 32-bit words (low word
// first), buffers them and streams them to the TA parameter parser. Every
// 8th word leaving the FIFO (end of a 32-byte parameter block) is marked last.
//   clk, rst  : clock, synchronous active-high reset
//   bus       : ta_fifo_in_if.slave (SH4 request/response + TA word stream)
//   level     : words currently buffered
//   mask_err  : sticky flag, a write with an unsupported byte mask was dropped
//   err_clr   : clears mask_err (wins over a same-cycle set)
module ta_fifo_in
  import ta_fifo_in_pkg::*;
#(
  parameter int          DEPTH  = 64,
  parameter logic [28:0] REG_HI = TA_FIFO_HI,
  parameter logic [28:0] REG_LO = TA_FIFO_LO
) (
  input  logic                    clk,
  input  logic                    rst,
  ta_fifo_in_if.slave             bus,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    mask_err,
  input  logic                    err_clr
);

  ta_state_e   state_q, state_d;
  logic        resp_valid_q, resp_valid_d;
  logic [63:0] data_q, data_d;
  logic [7:0]  mask_q, mask_d;
  logic [2:0]  blk_cnt_q, blk_cnt_d;
  logic        mask_err_q, mask_err_d;

  logic        hit;
  logic        mask_err_set;
  logic        push;
  logic [31:0] push_word;
  logic        pop;
  logic        full;
  logic        empty;
  logic [31:0] head_word;

  // Only addr[28:0] is decoded; the SH4 area bits above are don't-care.
  logic unused_addr_hi;
  assign unused_addr_hi = ^bus.req_addr[31:29];

  assign hit = bus.req_valid && in_region(bus.req_addr[28:0], REG_LO, REG_HI);
  assign pop = !empty && bus.ta_ready;

  // NOTE: every signal assigned here gets a default first, so no path leaves
  // it unassigned and no latch is inferred; combinational logic uses '='.
  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    mask_d       = mask_q;
    mask_err_set = 1'b0;
    push         = 1'b0;
    push_word    = data_q[31:0];

    unique case (state_q)
      IDLE: begin
        if (hit) begin
          data_d = bus.req_wdata;
          mask_d = bus.req_wmask;
          if (!bus.req_wen) begin
            state_d = ACK;
          end else begin
            case (bus.req_wmask)
              8'hFF, 8'h0F: state_d = PUSH_LO;
              8'hF0:        state_d = PUSH_HI;
              default: begin
                state_d      = ACK;
                mask_err_set = 1'b1;
              end
            endcase
          end
        end
      end
      PUSH_LO: begin
        // A full FIFO holds the FSM here, which withholds the ack and stalls the SH4.
        if (!full) begin
          push    = 1'b1;
          state_d = (mask_q == 8'hFF) ? PUSH_HI : ACK;
        end
      end
      PUSH_HI: begin
        if (!full) begin
          push      = 1'b1;
          push_word = data_q[63:32];
          state_d   = ACK;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    resp_valid_d = (state_d == ACK);
    mask_err_d   = err_clr ? 1'b0 : (mask_err_q | mask_err_set);
    blk_cnt_d    = blk_cnt_q + 3'(pop);
  end

  // NOTE: sequential state is updated with '<=' so all flops sample the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      resp_valid_q <= 1'b0;
      data_q       <= '0;
      mask_q       <= '0;
      blk_cnt_q    <= '0;
      mask_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      resp_valid_q <= resp_valid_d;
      data_q       <= data_d;
      mask_q       <= mask_d;
      blk_cnt_q    <= blk_cnt_d;
      mask_err_q   <= mask_err_d;
    end
  end

  sync_fifo_w32 #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (push_word),
    .pop   (pop),
    .rdata (head_word),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = '0;
  assign bus.ta_valid   = !empty;
  assign bus.ta_word    = head_word;
  assign bus.ta_last    = (blk_cnt_q == 3'd7);
  assign mask_err       = mask_err_q;

endmodule

// File: tb/tb_ta_fifo_in.sv
// Self-checking bench for ta_fifo_in: table-driven single requests, hand
// sequences for stall/reset/error corners, and a randomized phase checked
// against a queue-based model of the word stream.
module tb_ta_fifo_in;

  localparam int DEPTH = 64;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          err_clr;
  logic [LW-1:0] level;
  logic          mask_err;

  ta_fifo_in_if bus ();

  ta_fifo_in #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .level    (level),
    .mask_err (mask_err),
    .err_clr  (err_clr)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: words in acceptance order, pops since reset, error flag.
  logic [31:0] exp_q[$];
  int          n_pop = 0;
  logic        m_err = 1'b0;
  bit          rnd_ready = 1'b0;

  typedef struct {
    logic [31:0] addr;
    logic [63:0] data;
    logic [7:0]  mask;
    logic        wen;
    int          lat;   // cycles from capture to ack, -1 = no ack
    logic        err;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic bit is_hit(input logic [31:0] a);
    return (a[28:0] >= 29'h1000_0000) && (a[28:0] <= 29'h107F_FFFF);
  endfunction

  // A store places its enabled 32-bit halves into the stream, low half first.
  task automatic model_accept(input logic [31:0] addr, input logic [63:0] data,
                              input logic [7:0] mask, input logic wen);
    if (!is_hit(addr)) return;
    if (err_clr) m_err = 1'b0;
    if (!wen) return;
    if (mask == 8'hFF || mask == 8'h0F) exp_q.push_back(data[31:0]);
    if (mask == 8'hFF || mask == 8'hF0) exp_q.push_back(data[63:32]);
    if (mask != 8'hFF && mask != 8'h0F && mask != 8'hF0 && !err_clr) m_err = 1'b1;
  endtask

  task automatic model_reset();
    exp_q.delete();
    n_pop = 0;
    m_err = 1'b0;
  endtask

  // Pop monitor: samples 1 ns before the rising edge that performs the pop.
  always begin
    @(negedge clk);
    #4;
    if (!rst && bus.ta_valid && bus.ta_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL pop_unexpected: got word 0x%08h, model holds no word", bus.ta_word);
      end else begin
        logic [31:0] w;
        w = exp_q.pop_front();
        check($sformatf("pop_word[%0d]", n_pop), bus.ta_word, w);
        check($sformatf("pop_last[%0d]", n_pop), bus.ta_last, (n_pop % 8) == 7);
        n_pop++;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    if (rnd_ready) bus.ta_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic start_req(input logic [31:0] addr, input logic [63:0] data,
                           input logic [7:0] mask, input logic wen);
    bus.req_valid = 1'b1;
    bus.req_addr  = addr;
    bus.req_wdata = data;
    bus.req_wmask = mask;
    bus.req_wen   = wen;
    model_accept(addr, data, mask, wen);
  endtask

  task automatic wait_resp(input int budget, output int lat);
    lat = -1;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if (bus.resp_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic end_req();
    bus.req_valid = 1'b0;
    tick();
    check("resp_one_cycle", bus.resp_valid, 1'b0);
  endtask

  task automatic issue(input logic [31:0] addr, input logic [63:0] data,
                       input logic [7:0] mask, input logic wen,
                       input int budget, output int lat);
    start_req(addr, data, mask, wen);
    wait_resp(budget, lat);
    if (lat != -1) check("resp_rdata_zero", bus.resp_rdata, 64'h0);
    end_req();
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    m_err   = 1'b0;
  endtask

  task automatic drain(input int budget);
    rnd_ready    = 1'b0;
    bus.ta_ready = 1'b1;
    for (int i = 0; i < budget && bus.ta_valid; i++) tick();
    check("drain_level", level, exp_q.size());
    check("drain_ta_valid", bus.ta_valid, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    vec_t        vecs[13];
    int          lat;
    logic [31:0] addr;
    logic [63:0] data;
    logic [7:0]  mask;
    logic        wen;
    bit          hit;

    vecs[0]  = '{32'h1000_0000, 64'hAAAA_0001_BBBB_0001, 8'hFF, 1'b1,  3, 1'b0};
    vecs[1]  = '{32'h1000_0008, 64'hAAAA_0002_BBBB_0002, 8'h0F, 1'b1,  2, 1'b0};
    vecs[2]  = '{32'h1000_0010, 64'hAAAA_0003_BBBB_0003, 8'hF0, 1'b1,  2, 1'b0};
    vecs[3]  = '{32'h1000_0010, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF, 1'b0,  1, 1'b0};
    vecs[4]  = '{32'h107F_FFF8, 64'hAAAA_0005_BBBB_0005, 8'hFF, 1'b1,  3, 1'b0};
    vecs[5]  = '{32'h1080_0000, 64'hAAAA_0006_BBBB_0006, 8'hFF, 1'b1, -1, 1'b0};
    vecs[6]  = '{32'h0FFF_FFF8, 64'hAAAA_0007_BBBB_0007, 8'hFF, 1'b1, -1, 1'b0};
    vecs[7]  = '{32'hB000_0020, 64'hAAAA_0008_BBBB_0008, 8'h0F, 1'b1,  2, 1'b0};
    vecs[8]  = '{32'h1000_0040, 64'hAAAA_0009_BBBB_0009, 8'h3C, 1'b1,  1, 1'b1};
    vecs[9]  = '{32'h1000_0040, 64'hAAAA_000A_BBBB_000A, 8'h00, 1'b1,  1, 1'b1};
    vecs[10] = '{32'h005F_7C00, 64'hAAAA_000B_BBBB_000B, 8'hFF, 1'b1, -1, 1'b0};
    vecs[11] = '{32'h1000_0000, 64'hAAAA_000C_BBBB_000C, 8'h3C, 1'b0,  1, 1'b0};
    vecs[12] = '{32'h107F_FFFF, 64'hAAAA_000D_BBBB_000D, 8'hF0, 1'b1,  2, 1'b0};

    rst           = 1'b1;
    err_clr       = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_wmask = '0;
    bus.req_wen   = 1'b0;
    bus.ta_ready  = 1'b0;
    repeat (3) tick();

    // Reset state
    check("rst_resp_valid", bus.resp_valid, 1'b0);
    check("rst_resp_rdata", bus.resp_rdata, 64'h0);
    check("rst_ta_valid",   bus.ta_valid,   1'b0);
    check("rst_ta_last",    bus.ta_last,    1'b0);
    check("rst_level",      level,          0);
    check("rst_mask_err",   mask_err,       1'b0);
    rst = 1'b0;
    tick();

    // Block marking: 8 words then a 9th, ta_last only on the 8th
    for (int i = 0; i < 4; i++) begin
      issue(32'h1000_0000 + 32'(i * 8), {32'hB100_0000 + 32'(2*i+1), 32'hB100_0000 + 32'(2*i)},
            8'hFF, 1'b1, 8, lat);
      check("blk_lat", lat, 3);
    end
    check("blk_level8", level, 8);
    check("blk_head_not_last", bus.ta_last, 1'b0);
    drain(20);
    issue(32'h1000_0020, 64'h0000_0000_B100_0008, 8'h0F, 1'b1, 8, lat);
    drain(10);

    // Basic FF write: low word first, ack 3 cycles after capture
    bus.ta_ready = 1'b0;
    issue(32'h1000_0000, 64'h1111_2222_3333_4444, 8'hFF, 1'b1, 8, lat);
    check("t1_lat", lat, 3);
    check("t1_level", level, 2);
    check("t1_head", bus.ta_word, 32'h3333_4444);
    drain(10);

    // Table of single requests, consumer always ready
    for (int v = 0; v < 13; v++) begin
      pulse_clr();
      start_req(vecs[v].addr, vecs[v].data, vecs[v].mask, vecs[v].wen);
      wait_resp(vecs[v].lat == -1 ? 6 : 8, lat);
      check($sformatf("vec%0d_lat", v), lat, vecs[v].lat);
      if (lat != -1) check($sformatf("vec%0d_rdata", v), bus.resp_rdata, 64'h0);
      check($sformatf("vec%0d_mask_err", v), mask_err, vecs[v].err);
      end_req();
      drain(10);
    end

    // Sticky error cleared by err_clr
    bus.ta_ready = 1'b0;
    issue(32'h1000_0100, 64'h0, 8'h3C, 1'b1, 8, lat);
    check("t4_lat", lat, 1);
    check("t4_level", level, 0);
    check("t4_err_set", mask_err, 1'b1);
    tick();
    check("t4_err_sticky", mask_err, 1'b1);
    pulse_clr();
    check("t4_err_cleared", mask_err, 1'b0);

    // err_clr wins over a same-cycle set
    err_clr = 1'b1;
    start_req(32'h1000_0100, 64'h0, 8'h81, 1'b1);
    wait_resp(8, lat);
    err_clr = 1'b0;
    check("clr_prio_lat", lat, 1);
    check("clr_prio_err", mask_err, 1'b0);
    end_req();
    check("clr_prio_model", mask_err, m_err);

    // Fill to DEPTH: 33rd write stalls until the consumer drains a word
    bus.ta_ready = 1'b0;
    for (int i = 0; i < 32; i++) begin
      issue(32'h1000_0000 + 32'(i * 8), {$urandom, $urandom}, 8'hFF, 1'b1, 8, lat);
      check($sformatf("fill%0d_lat", i), lat, 3);
    end
    check("full_level", level, 64);
    start_req(32'h1000_0100, 64'hCAFE_0033_BEEF_0033, 8'hFF, 1'b1);
    wait_resp(20, lat);
    check("full_no_ack", lat, -1);
    check("full_level_held", level, 64);
    bus.ta_ready = 1'b1;
    wait_resp(12, lat);
    check("full_release_ack", lat != -1, 1'b1);
    end_req();
    drain(100);

    // Reset in the middle of a request
    bus.ta_ready = 1'b0;
    issue(32'h1000_0000, 64'h0101_0101_0202_0202, 8'hFF, 1'b1, 8, lat);
    issue(32'h1000_0008, 64'h0303_0303_0404_0404, 8'hFF, 1'b1, 8, lat);
    start_req(32'h1000_0010, 64'h0505_0505_0606_0606, 8'hFF, 1'b1);
    tick();
    tick();
    check("t6_level_before", level, 5);
    check("t6_no_ack_yet", bus.resp_valid, 1'b0);
    rst           = 1'b1;
    bus.req_valid = 1'b0;
    model_reset();
    tick();
    rst = 1'b0;
    check("t6_level_flushed", level, 0);
    check("t6_ta_valid", bus.ta_valid, 1'b0);
    check("t6_no_ack", bus.resp_valid, 1'b0);
    tick();
    check("t6_no_late_ack", bus.resp_valid, 1'b0);
    bus.ta_ready = 1'b1;
    issue(32'h1000_0000, 64'h0707_0707_0808_0808, 8'hFF, 1'b1, 8, lat);
    check("t6_after_lat", lat, 3);
    drain(10);

    // Randomized traffic with a randomly stalling consumer
    rnd_ready = 1'b1;
    for (int n = 0; n < 150; n++) begin
      hit  = ($urandom_range(0, 9) < 8);
      addr = {3'($urandom_range(0, 7)),
              (hit ? 29'h1000_0000 : 29'h1080_0000) + 29'($urandom_range(0, 32'h7F_FFFF))};
      data = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0:       mask = 8'hFF;
        1:       mask = 8'h0F;
        2:       mask = 8'hF0;
        default: mask = 8'($urandom);
      endcase
      wen = ($urandom_range(0, 3) != 0);
      start_req(addr, data, mask, wen);
      wait_resp(hit ? 40 : 5, lat);
      if (hit) check("rnd_ack", lat != -1, 1'b1);
      else     check("rnd_miss_no_ack", lat, -1);
      end_req();
      check("rnd_mask_err", mask_err, m_err);
      check("rnd_level", level, exp_q.size());
      if ($urandom_range(0, 7) == 0) begin
        pulse_clr();
        check("rnd_err_clr", mask_err, 1'b0);
      end
    end
    drain(200);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
